// File: rtl/smps_pkg.sv
// Shared SMPS controller types and default sizing.
// Holds the gate FSM state encoding used by the gate driver.
package smps_pkg;

  localparam int DUTY_W_DEF    = 8;
  localparam int PERIOD_DEF    = 10;
  localparam int DEAD_TIME_DEF = 2;

  typedef enum logic [2:0] {
    OFF,
    DT_LH,
    LOW_ON,
    DT_HL,
    HIGH_ON
  } gate_st_e;

endpackage

// File: rtl/dead_time_ctrl.sv
// Complementary gate FSM with dead-time insertion between
// high-side and low-side conduction.
module dead_time_ctrl
  import smps_pkg::*;
#(
  parameter int DEAD_TIME = DEAD_TIME_DEF
) (
  input  logic i_clk,
  input  logic reset,
  input  logic i_hi_req,
  input  logic i_run,
  output logic o_gate_h,
  output logic o_gate_l
);

  localparam int DW = $clog2(DEAD_TIME + 1);
  localparam logic [DW-1:0] DT_LAST = DW'(DEAD_TIME - 1);

  gate_st_e      state_q;
  logic [DW-1:0] dt_q;
  logic          gate_h_q;
  logic          gate_l_q;
  logic          dt_done;

  assign dt_done  = (dt_q == DT_LAST);
  assign o_gate_h = gate_h_q;
  assign o_gate_l = gate_l_q;

  // Gates are registered alongside the next state
  always_ff @(posedge i_clk or posedge reset) begin
    if (reset) begin
      state_q  <= OFF;
      dt_q     <= '0;
      gate_h_q <= 1'b0;
      gate_l_q <= 1'b0;
    end else if (!i_run) begin
      state_q  <= OFF;
      dt_q     <= '0;
      gate_h_q <= 1'b0;
      gate_l_q <= 1'b0;
    end else begin
      unique case (state_q)
        OFF: begin
          state_q  <= DT_LH;
          dt_q     <= '0;
          gate_h_q <= 1'b0;
          gate_l_q <= 1'b0;
        end
        DT_LH: begin
          if (dt_done) begin
            dt_q <= '0;
            if (i_hi_req) begin
              state_q  <= HIGH_ON;
              gate_h_q <= 1'b1;
            end else begin
              state_q  <= LOW_ON;
              gate_l_q <= 1'b1;
            end
          end else begin
            dt_q <= dt_q + DW'(1);
          end
        end
        LOW_ON: begin
          if (i_hi_req) begin
            state_q  <= DT_HL;
            dt_q     <= '0;
            gate_l_q <= 1'b0;
          end
        end
        DT_HL: begin
          if (!i_hi_req) begin
            state_q  <= LOW_ON;
            dt_q     <= '0;
            gate_l_q <= 1'b1;
          end else if (dt_done) begin
            state_q  <= HIGH_ON;
            dt_q     <= '0;
            gate_h_q <= 1'b1;
          end else begin
            dt_q <= dt_q + DW'(1);
          end
        end
        HIGH_ON: begin
          if (!i_hi_req) begin
            state_q  <= DT_LH;
            dt_q     <= '0;
            gate_h_q <= 1'b0;
          end
        end
        default: begin
          state_q  <= OFF;
          dt_q     <= '0;
          gate_h_q <= 1'b0;
          gate_l_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/pwm_gate_gen.sv
// SMPS switching-period generator and gate driver.
// Define PWM_DEAD_TIME_EN for complementary drive with dead time.
module pwm_gate_gen
  import smps_pkg::*;
#(
  parameter int DUTY_W    = DUTY_W_DEF,
  parameter int PERIOD    = PERIOD_DEF,
  parameter int DEAD_TIME = DEAD_TIME_DEF
) (
  input  logic              i_clk,
  input  logic              reset,
  input  logic              i_enable,
  input  logic [DUTY_W-1:0] i_duty_sel,
  output logic              o_gate_h,
  output logic              o_gate_l,
  output logic              o_period_start,
  output logic [DUTY_W-1:0] o_duty_applied
);

  localparam int CW = $clog2(PERIOD);
  localparam logic [CW-1:0] CNT_LAST = CW'(PERIOD - 1);
  localparam logic [DUTY_W-1:0] DUTY_MAX = DUTY_W'(PERIOD);

  if (PERIOD < 2 || DEAD_TIME < 1 || DEAD_TIME > PERIOD / 2)
  begin : g_bad_cfg
    $error("pwm_gate_gen: bad PERIOD/DEAD_TIME");
  end

  logic              run_q;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [DUTY_W-1:0] duty_q, duty_d;
  logic [DUTY_W-1:0] duty_clamp;
  logic              ps_q;
  logic              at_last;
  logic              load;
  logic              hi_req;

  always_comb begin
    duty_clamp = i_duty_sel;
    if (i_duty_sel > DUTY_MAX) duty_clamp = DUTY_MAX;
    at_last = (cnt_q == CNT_LAST);
    // Shadow loads on run start and on each period boundary
    load    = (i_enable && !run_q) || (run_q && at_last);
    duty_d  = load ? duty_clamp : duty_q;
    cnt_d   = '0;
    if (i_enable && run_q && !at_last) cnt_d = cnt_q + CW'(1);
    hi_req  = run_q && (DUTY_W'(cnt_q) < duty_q);
  end

  always_ff @(posedge i_clk or posedge reset) begin
    if (reset) begin
      run_q  <= 1'b0;
      cnt_q  <= '0;
      duty_q <= '0;
      ps_q   <= 1'b0;
    end else begin
      run_q  <= i_enable;
      cnt_q  <= cnt_d;
      duty_q <= duty_d;
      ps_q   <= run_q && (cnt_q == '0);
    end
  end

  assign o_period_start = ps_q;
  assign o_duty_applied = duty_q;

`ifdef PWM_DEAD_TIME_EN
  dead_time_ctrl #(
    .DEAD_TIME(DEAD_TIME)
  ) u_dtc (
    .i_clk   (i_clk),
    .reset   (reset),
    .i_hi_req(hi_req),
    .i_run   (run_q),
    .o_gate_h(o_gate_h),
    .o_gate_l(o_gate_l)
  );
`else
  logic gate_h_q;

  always_ff @(posedge i_clk or posedge reset) begin
    if (reset) gate_h_q <= 1'b0;
    else       gate_h_q <= hi_req;
  end

  assign o_gate_h = gate_h_q;
  assign o_gate_l = 1'b0;
`endif

endmodule

// File: tb/tb_pwm_gate_gen.sv
// Directed bench for pwm_gate_gen, PERIOD 10, DEAD_TIME 2.
// Expectations follow whichever PWM_DEAD_TIME_EN build is compiled.
module tb_pwm_gate_gen;

`ifdef PWM_DEAD_TIME_EN
  localparam bit DT_EN = 1'b1;
`else
  localparam bit DT_EN = 1'b0;
`endif

  localparam logic [9:0] GH4 = DT_EN ? 10'b0000011000 : 10'b0000011110;
  localparam logic [9:0] GL4 = DT_EN ? 10'b1110000001 : 10'b0000000000;
  localparam logic [9:0] GH6 = DT_EN ? 10'b0001111000 : 10'b0001111110;
  localparam logic [9:0] GL6 = DT_EN ? 10'b1000000001 : 10'b0000000000;
  localparam int NV = 42;

  typedef struct {
    logic       en;
    logic [7:0] duty;
    logic       gh;
    logic       gl;
    logic       ps;
    logic [7:0] dapp;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [7:0] duty;
  logic       gh, gl, ps;
  logic [7:0] dapp;

  int n_cmp = 0;
  int n_bad = 0;
  vec_t tbl [NV];

  always #5 clk = ~clk;

  pwm_gate_gen #(
    .DUTY_W   (8),
    .PERIOD   (10),
    .DEAD_TIME(2)
  ) dut (
    .i_clk         (clk),
    .reset         (rst),
    .i_enable      (en),
    .i_duty_sel    (duty),
    .o_gate_h      (gh),
    .o_gate_l      (gl),
    .o_period_start(ps),
    .o_duty_applied(dapp)
  );

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    n_cmp++;
    if (gh && gl) begin
      n_bad++;
      $display("FAIL overlap: gate_h=%0b gate_l=%0b, expected not both 1",
               gh, gl);
    end
  endtask

  task automatic win(input int n, output int ch, output int cl);
    ch = 0;
    cl = 0;
    for (int i = 0; i < n; i++) begin
      tick();
      ch += int'(gh);
      cl += int'(gl);
    end
  endtask

  initial begin
    int ch, cl, c;
    logic [9:0] ghp, glp;

    for (int k = 0; k < NV; k++) begin
      c = k % 10;
      tbl[k].en   = 1'b1;
      tbl[k].duty = (k < 26) ? 8'd4 : 8'd6;
      tbl[k].dapp = (k < 30) ? 8'd4 : 8'd6;
      ghp = (k < 30) ? GH4 : GH6;
      glp = (k < 30) ? GL4 : GL6;
      tbl[k].gh = ghp[c];
      tbl[k].gl = glp[c];
      tbl[k].ps = (c == 1);
    end
    tbl[0].gl = 1'b0;

    rst  = 1'b1;
    en   = 1'b0;
    duty = 8'd0;
    tick();
    tick();
    chk("rst_gate_h", int'(gh), 0);
    chk("rst_gate_l", int'(gl), 0);
    chk("rst_ps", int'(ps), 0);
    chk("rst_duty", int'(dapp), 0);
    rst = 1'b0;

    for (int k = 0; k < NV; k++) begin
      en   = tbl[k].en;
      duty = tbl[k].duty;
      tick();
      chk($sformatf("vec%0d_gate_h", k), int'(gh), int'(tbl[k].gh));
      chk($sformatf("vec%0d_gate_l", k), int'(gl), int'(tbl[k].gl));
      chk($sformatf("vec%0d_ps", k), int'(ps), int'(tbl[k].ps));
      chk($sformatf("vec%0d_duty", k), int'(dapp), int'(tbl[k].dapp));
    end

    en = 1'b0;
    tick();
    tick();
    chk("drop_gate_h", int'(gh), 0);
    chk("drop_gate_l", int'(gl), 0);
    chk("drop_ps", int'(ps), 0);
    tick();
    chk("drop_ps2", int'(ps), 0);

    en   = 1'b1;
    duty = 8'd1;
    tick();
    chk("re_duty", int'(dapp), 1);
    chk("re_ps0", int'(ps), 0);
    tick();
    chk("re_ps1", int'(ps), 1);
    win(10, ch, cl);
    win(30, ch, cl);
    chk("d1_gate_h_cnt", ch, DT_EN ? 0 : 3);
    chk("d1_gate_l_cnt", cl, DT_EN ? 27 : 0);

    duty = 8'd0;
    win(12, ch, cl);
    chk("d0_duty", int'(dapp), 0);
    win(30, ch, cl);
    chk("d0_gate_h_cnt", ch, 0);
    chk("d0_gate_l_cnt", cl, DT_EN ? 30 : 0);

    en = 1'b0;
    tick();
    tick();
    en   = 1'b1;
    duty = 8'd200;
    tick();
    chk("big_duty", int'(dapp), 10);
    chk("big_gate_h1", int'(gh), 0);
    tick();
    chk("big_ps", int'(ps), 1);
    chk("big_gate_h2", int'(gh), DT_EN ? 0 : 1);
    tick();
    chk("big_gate_h3", int'(gh), DT_EN ? 0 : 1);
    tick();
    chk("big_gate_h4", int'(gh), 1);
    win(20, ch, cl);
    chk("big_gate_h_cnt", ch, 20);
    chk("big_gate_l_cnt", cl, 0);
    chk("pre_rst_gate_h", int'(gh), 1);

    #2 rst = 1'b1;
    #1;
    chk("arst_gate_h", int'(gh), 0);
    chk("arst_gate_l", int'(gl), 0);
    chk("arst_duty", int'(dapp), 0);
    chk("arst_ps", int'(ps), 0);
    duty = 8'd4;
    #2 rst = 1'b0;
    tick();
    chk("rel_duty", int'(dapp), 4);
    chk("rel_ps0", int'(ps), 0);
    tick();
    chk("rel_ps1", int'(ps), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
